// File: rtl/generic_bus_sram_responder.sv
// Word-organised on-chip RAM responder for the generic bus (byte-lane writes, full-word reads, error completions).
// Latency: accept edge N, busy low during the cycle after edge N+LATENCY+1 (plus 0..3 extra cycles with stall injection).
// Backpressure: busy stays high until the single completion cycle; a dropped request in WAIT aborts with no side effects.
//
// Ports: CLK/nRST (async active-low), bus_addr/bus_ren/bus_wen/bus_wdata/bus_byte_en in,
//        bus_rdata/bus_busy/bus_error out (these bind to the generic_bus modport signals of the same name).
// Optional feature macro: GENERIC_BUS_SRAM_STALL_INJECT_EN adds an 8-bit LFSR that stretches each
// transfer by 0..3 pseudo-random wait cycles.
module generic_bus_sram_responder #(
    parameter int                         RAM_ADDR_SIZE = 32,
    parameter int                         DEPTH_WORDS   = 1024,
    parameter int                         LATENCY       = 2,
    parameter logic [RAM_ADDR_SIZE-1:0]   BASE_ADDR     = '0
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic [RAM_ADDR_SIZE-1:0]  bus_addr,
    input  logic                      bus_ren,
    input  logic                      bus_wen,
    input  logic [31:0]               bus_wdata,
    input  logic [3:0]                bus_byte_en,
    output logic [31:0]               bus_rdata,
    output logic                      bus_busy,
    output logic                      bus_error
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = 5;   // holds LATENCY (<=15) plus up to 3 injected cycles
    localparam logic [CNT_W-1:0]         LAT_C = CNT_W'(LATENCY);
    localparam logic [RAM_ADDR_SIZE-1:0] SPAN  = RAM_ADDR_SIZE'(DEPTH_WORDS * 4);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [RAM_ADDR_SIZE-1:0]   addr_q, addr_d;
    logic [31:0]                wdata_q, wdata_d;
    logic [3:0]                 be_q, be_d;
    logic                       wr_q, wr_d;
    logic                       illegal_q, illegal_d;
    logic                       busy_q, busy_d;
    logic                       error_q, error_d;
    logic [31:0]                rdata_q, rdata_d;

    logic [31:0]                mem [DEPTH_WORDS];

    logic [RAM_ADDR_SIZE-1:0]   offset;
    logic [IDX_W-1:0]           idx;
    logic                       out_of_range;
    logic                       fail;
    logic [1:0]                 extra;

`ifdef GENERIC_BUS_SRAM_STALL_INJECT_EN
    logic [7:0] lfsr_q, lfsr_d;

    // Taps 8,6,5,4; shifting a nonzero seed through this polynomial never yields zero.
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        extra  = lfsr_q[1:0];
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) lfsr_q <= 8'hA5;
        else       lfsr_q <= lfsr_d;
    end
`else
    assign extra = 2'b00;
`endif

    // Range is judged on the latched address; a byte offset >= 4*DEPTH is the same as index >= DEPTH.
    always_comb begin
        offset       = addr_q - BASE_ADDR;
        idx          = offset[IDX_W+1:2];
        out_of_range = (addr_q < BASE_ADDR) || (offset >= SPAN);
        fail         = out_of_range || illegal_q;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        wr_d      = wr_q;
        illegal_d = illegal_q;
        busy_d    = 1'b1;
        error_d   = 1'b0;
        rdata_d   = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (bus_ren || bus_wen) begin
                    addr_d    = bus_addr;
                    wdata_d   = bus_wdata;
                    be_d      = bus_byte_en;
                    wr_d      = bus_wen;
                    illegal_d = bus_ren && bus_wen;
                    cnt_d     = LAT_C + {3'b000, extra};
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!(bus_ren || bus_wen)) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    // Outputs are registered, so the completion values are computed on entry to DONE.
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    error_d = fail;
                    if (!fail && !wr_q) rdata_d = mem[idx];
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            wr_q      <= 1'b0;
            illegal_q <= 1'b0;
            busy_q    <= 1'b1;
            error_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            wr_q      <= wr_d;
            illegal_q <= illegal_d;
            busy_q    <= busy_d;
            error_q   <= error_d;
            rdata_q   <= rdata_d;
        end
    end

    // Write commits at the edge that leaves DONE; reset forces IDLE so no partial write can occur.
    always_ff @(posedge CLK) begin
        if (state_q == ST_DONE && wr_q && !fail) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

    assign bus_rdata = rdata_q;
    assign bus_busy  = busy_q;
    assign bus_error = error_q;

endmodule

// File: tb/tb_generic_bus_sram_responder.sv
module tb_generic_bus_sram_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] addr = '0;
    logic        ren = 1'b0;
    logic        wen = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = '0;
    logic [31:0] rdata;
    logic        busy;
    logic        error;

    generic_bus_sram_responder #(
        .RAM_ADDR_SIZE (32),
        .DEPTH_WORDS   (DEPTH),
        .LATENCY       (LAT),
        .BASE_ADDR     (32'h0000_0000)
    ) dut (
        .CLK         (clk),
        .nRST        (rst_n),
        .bus_addr    (addr),
        .bus_ren     (ren),
        .bus_wen     (wen),
        .bus_wdata   (wdata),
        .bus_byte_en (be),
        .bus_rdata   (rdata),
        .bus_busy    (busy),
        .bus_error   (error)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          edge_cnt = 0;
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] m_rdata = '0;

    // Number of clock edges since reset release = number of LFSR advances.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

`ifdef GENERIC_BUS_SRAM_STALL_INJECT_EN
    // Sequence value after n steps from seed 0xA5, feedback = x8^x6^x5^x4.
    function automatic logic [7:0] lfsr_after(input int n);
        logic [7:0] v;
        v = 8'hA5;
        for (int k = 0; k < n; k++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
        return v;
    endfunction
`endif

    // One complete transfer; the reference result comes from the memory model in ref_mem.
    task automatic do_xfer(input logic r, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] b, input string tag);
        int          cyc;
        int          exp_delay;
        logic        oor;
        logic        err;
        logic [31:0] exp_rd;
        logic [31:0] widx;
        @(negedge clk);
`ifdef GENERIC_BUS_SRAM_STALL_INJECT_EN
        begin
            logic [7:0] l;
            l = lfsr_after(edge_cnt);
            exp_delay = LAT + 1 + int'(l[1:0]);
        end
`else
        exp_delay = LAT + 1;
`endif
        ren = r; wen = w; addr = a; wdata = d; be = b;
        cyc = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            // Disturb the bus fields mid-wait; the responder must use its latched copy.
            if (busy && cyc == 1) begin
                addr  = ~a;
                wdata = ~d;
                be    = ~b;
            end
        end while (busy && cyc < 40);
        if (busy) begin
            check_eq({tag, "_timeout"}, 32'(busy), 32'd0);
            ren = 1'b0; wen = 1'b0;
            return;
        end
        widx = {2'b00, a[31:2]};
        oor  = widx >= 32'(DEPTH);
        err  = (r && w) || oor;
        exp_rd = (r && !w && !err) ? ref_mem[widx[9:0]] : m_rdata;
        check_eq({tag, "_delay"}, 32'(cyc - 1), 32'(exp_delay));
        check_eq({tag, "_error"}, 32'(error), 32'(err));
        check_eq({tag, "_rdata"}, rdata, exp_rd);
        m_rdata = exp_rd;
        if (w && !r && !err) begin
            for (int i = 0; i < 4; i++)
                if (b[i]) ref_mem[widx[9:0]][8*i +: 8] = d[8*i +: 8];
        end
        ren = 1'b0; wen = 1'b0;
    endtask

    initial begin
        logic        saw_low;
        logic        saw_err;
        int          pick;
        int          op;
        int          ridx;
        logic [31:0] ra;

        // Reset and check reset values while reset is held.
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy",  32'(busy),  32'd1);
        check_eq("rst_error", 32'(error), 32'd0);
        check_eq("rst_rdata", rdata,      32'd0);
        rst_n = 1'b1;

        // Prefill the words used below with known data.
        for (int i = 0; i < 17; i++) begin
            ridx = (i == 16) ? 1023 : i;
            do_xfer(1'b0, 1'b1, 32'(ridx) << 2, $urandom, 4'hF, "prefill");
        end

        // Directed cases.
        do_xfer(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "wr_full");
        do_xfer(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, "rd_full");
        check_eq("rd_full_value", rdata, 32'hDEADBEEF);
        do_xfer(1'b0, 1'b1, 32'h10, 32'h11223344, 4'b0101, "wr_part");
        do_xfer(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, "rd_part");
        check_eq("rd_part_value", rdata, 32'hDE22BE44);
        do_xfer(1'b1, 1'b0, 32'h1000, 32'h0, 4'hF, "rd_oor");
        do_xfer(1'b1, 1'b0, 32'h0FFC, 32'h0, 4'hF, "rd_last");
        do_xfer(1'b1, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'hF, "illegal");
        do_xfer(1'b1, 1'b0, 32'h20, 32'h0, 4'hF, "rd_after_illegal");
        do_xfer(1'b0, 1'b1, 32'h1004, 32'h5555_AAAA, 4'hF, "wr_oor");
        do_xfer(1'b0, 1'b1, 32'h14, 32'h1234_5678, 4'h0, "wr_no_lanes");
        do_xfer(1'b1, 1'b0, 32'h14, 32'h0, 4'hF, "rd_no_lanes");

        // Abort: request held for one cycle only.
        @(negedge clk);
        ren = 1'b1; addr = 32'h3C;
        @(negedge clk);
        ren = 1'b0;
        saw_low = 1'b0;
        saw_err = 1'b0;
        repeat (LAT + 8) begin
            @(negedge clk);
            if (!busy) saw_low = 1'b1;
            if (error) saw_err = 1'b1;
        end
        check_eq("abort_busy_low", 32'(saw_low), 32'd0);
        check_eq("abort_error",    32'(saw_err), 32'd0);
        do_xfer(1'b1, 1'b0, 32'h3C, 32'h0, 4'hF, "rd_after_abort");

        // Reset pulsed while a write to word 12 is waiting.
        @(negedge clk);
        wen = 1'b1; addr = 32'h30; wdata = ~ref_mem[12]; be = 4'hF;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_busy",  32'(busy),  32'd1);
        check_eq("midrst_rdata", rdata,      32'd0);
        check_eq("midrst_error", 32'(error), 32'd0);
        wen = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_rdata = '0;
        do_xfer(1'b1, 1'b0, 32'h30, 32'h0, 4'hF, "rd_after_rst");

        // Randomized traffic over the prefilled words plus out-of-range addresses.
        for (int t = 0; t < 100; t++) begin
            pick = int'($urandom_range(0, 9));
            if (pick < 8)       ridx = int'($urandom_range(0, 15));
            else if (pick == 8) ridx = 1023;
            else                ridx = 1024 + int'($urandom_range(0, 40));
            ra = (32'(ridx) << 2) | 32'($urandom_range(0, 3));
            op = int'($urandom_range(0, 9));
            do_xfer(op == 0 || op > 5, op <= 5, ra, $urandom, 4'($urandom), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
